// File: rtl/io_arb_pkg.sv
// Shared types and constants for the IO pin-bus arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package io_arb_pkg;

  // Legal parameter ranges for io_port_arbiter.
  localparam int NUM_REQ_MIN     = 2;
  localparam int NUM_REQ_MAX     = 4;
  localparam int TURN_CYCLES_MIN = 1;
  localparam int TURN_CYCLES_MAX = 7;

  typedef logic [7:0] byte_t;
  typedef logic [1:0] req_idx_t;   // wide enough for NUM_REQ_MAX requesters
  typedef logic [2:0] turn_cnt_t;  // wide enough for TURN_CYCLES_MAX - 1

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_TURN,
    ST_SAMPLE,
    ST_RECOVER
  } state_t;

  function automatic logic [NUM_REQ_MAX-1:0] idx_to_onehot(input req_idx_t idx);
    logic [NUM_REQ_MAX-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner select: one-hot winner among req, searching from ptr+1 upward with wrap.
// Latency: combinational.
// Backpressure: none; win is zero when req is zero.
// Ports: req (request vector), ptr (index of last granted requester), win (one-hot winner).
module rr_picker
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic [NUM_REQ-1:0] win
);

  always_comb begin
    int   idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    // Visit ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); the last one visited is ptr itself.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/io_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto a shared 8-bit bidirectional pin bus, one byte per grant.
// Latency: req seen in IDLE at cycle N -> write done at N+2, read done at N+2+TURN_CYCLES.
// Backpressure: requesters hold req until their done pulse; requests outside IDLE wait.
// Ports: clk, rst_n (async, active-high); req/wr/wdata per requester; gnt/done one-hot;
//        rdata last sampled byte; busy; uio_in/uio_out/uio_oe pin bus (oe 1 = output).
// Build option: define IO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module io_port_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   wr,
  input  logic [NUM_REQ*8-1:0] wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output byte_t                rdata,
  output logic                 busy,
  input  byte_t                uio_in,
  output byte_t                uio_out,
  output byte_t                uio_oe
);

  localparam turn_cnt_t TURN_LAST = turn_cnt_t'(TURN_CYCLES - 1);

  state_t                 state;
  state_t                 state_nxt;
  turn_cnt_t              cnt;
  req_idx_t               owner;
  byte_t                  wbyte;
  req_idx_t               ptr;
  logic [NUM_REQ-1:0]     win;
  req_idx_t               win_idx;
  logic                   win_wr;
  byte_t                  win_wdata;
  logic [NUM_REQ_MAX-1:0] owner_oh;
  logic                   start;

  assign start = (state == ST_IDLE) && (|req);

`ifdef IO_ARB_FIXED_PRIO_EN
  // Pinning the pointer to the top index makes the picker search from 0 every time.
  assign ptr = req_idx_t'(NUM_REQ - 1);
`else
  // Reset value NUM_REQ-1 puts requester 0 first in line.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ptr <= req_idx_t'(NUM_REQ - 1);
    end else if (start) begin
      ptr <= win_idx;
    end
  end
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  // Decode the one-hot winner into its index, direction and write byte.
  always_comb begin
    win_idx   = '0;
    win_wr    = 1'b0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_idx   = req_idx_t'(i);
        win_wr    = wr[i];
        win_wdata = wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      owner <= '0;
      wbyte <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      // cnt measures time spent in TURN/RECOVER; restarts on every state change.
      if ((state_nxt == state) && ((state == ST_TURN) || (state == ST_RECOVER))) begin
        cnt <= cnt + 3'd1;
      end else begin
        cnt <= '0;
      end
      // Transaction parameters are captured once, so later req/wr/wdata changes cannot alter it.
      if (start) begin
        owner <= win_idx;
        wbyte <= win_wdata;
      end
      if (state == ST_SAMPLE) begin
        rdata <= uio_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|req) state_nxt = win_wr ? ST_DRIVE : ST_TURN;
      ST_DRIVE:   state_nxt = ST_RECOVER;
      ST_TURN:    if (cnt == TURN_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE:  state_nxt = ST_RECOVER;
      ST_RECOVER: if (cnt == TURN_LAST) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase

    owner_oh = idx_to_onehot(owner);
    busy     = (state != ST_IDLE);
    gnt      = busy ? owner_oh[NUM_REQ-1:0] : '0;
    // done fires only in the first RECOVER cycle.
    done     = ((state == ST_RECOVER) && (cnt == '0)) ? owner_oh[NUM_REQ-1:0] : '0;
    uio_oe   = (state == ST_DRIVE) ? 8'hFF : 8'h00;
    uio_out  = (state == ST_DRIVE) ? wbyte : 8'h00;
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// Self-checking bench for io_port_arbiter (NUM_REQ=2, TURN_CYCLES=1).
// Stimulus pushes expected completions into a scoreboard; a negedge monitor pops and compares.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_io_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [15:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  always #5 clk = ~clk;

  io_port_arbiter #(.NUM_REQ(2), .TURN_CYCLES(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wr      (wr),
    .wdata   (wdata),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .busy    (busy),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    int         owner;
    bit         is_read;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   total  = 0;
  int   bad    = 0;
  bit   mon_en = 1'b0;

  // Hand-computed grant orders with both requesters held.
`ifdef IO_ARB_FIXED_PRIO_EN
  int t3_own [4] = '{0, 0, 0, 0};
  int t5_own [2] = '{0, 0};
`else
  int t3_own [4] = '{0, 1, 0, 1};
  int t5_own [2] = '{0, 1};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int owner, input bit is_read, input logic [7:0] data);
    exp_t e;
    e.owner   = owner;
    e.is_read = is_read;
    e.data    = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count done pulses up to a cycle budget; a shortfall is reported as a failure.
  task automatic wait_dones(input int n, input int budget, input string name);
    int got;
    got = 0;
    for (int c = 0; (c < budget) && (got < n); c++) begin
      @(negedge clk);
      if (done != 2'b00) got++;
    end
    chk(name, got, n);
  endtask

  // Monitor: completions against the scoreboard, pin bus against the in-flight transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {30'd0, done}, 32'd0);
        end else begin
          e_mon = sb.pop_front();
          chk("done_owner", {30'd0, done}, 32'd1 << e_mon.owner);
          if (e_mon.is_read) chk("rdata", {24'd0, rdata}, {24'd0, e_mon.data});
        end
      end
      if (uio_oe == 8'hFF) begin
        if (sb.size() > 0) begin
          chk("drive_data", {24'd0, uio_out}, {24'd0, sb[0].data});
          chk("drive_gnt", {30'd0, gnt}, 32'd1 << sb[0].owner);
        end
      end else begin
        chk("pins_released", {16'd0, uio_oe, uio_out}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b1;
    req    = 2'b00;
    wr     = 2'b00;
    wdata  = 16'h0000;
    uio_in = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt",     {30'd0, gnt},     32'd0);
    chk("rst_done",    {30'd0, done},    32'd0);
    chk("rst_rdata",   {24'd0, rdata},   32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_uio_oe",  {24'd0, uio_oe},  32'd0);
    chk("rst_uio_out", {24'd0, uio_out}, 32'd0);
    tick();
    rst_n  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single write from requester 0; this cycle is N.
    req   = 2'b01;
    wr    = 2'b01;
    wdata = 16'h00A5;
    push_exp(0, 1'b0, 8'hA5);
    @(negedge clk);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);                                  // N+1: DRIVE
    chk("t1_oe",   {24'd0, uio_oe},  32'hFF);
    chk("t1_out",  {24'd0, uio_out}, 32'hA5);
    chk("t1_gnt",  {30'd0, gnt},     32'd1);
    chk("t1_busy", {31'd0, busy},    32'd1);
    @(negedge clk);                                  // N+2: RECOVER
    chk("t1_done", {30'd0, done},   32'd1);
    chk("t1_oe2",  {24'd0, uio_oe}, 32'd0);
    tick();
    req = 2'b00;
    @(negedge clk);                                  // N+3: IDLE
    chk("t1_gnt_end",  {30'd0, gnt},  32'd0);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);

    // Single read from requester 1.
    tick();
    req    = 2'b10;
    wr     = 2'b00;
    uio_in = 8'h3C;
    push_exp(1, 1'b1, 8'h3C);
    @(negedge clk);                                  // N
    @(negedge clk);                                  // N+1: TURN
    chk("t2_oe_turn", {24'd0, uio_oe}, 32'd0);
    chk("t2_gnt",     {30'd0, gnt},    32'd2);
    @(negedge clk);                                  // N+2: SAMPLE
    chk("t2_oe_sample", {24'd0, uio_oe}, 32'd0);
    chk("t2_no_done",   {30'd0, done},   32'd0);
    @(negedge clk);                                  // N+3: RECOVER
    chk("t2_done",  {30'd0, done},  32'd2);
    chk("t2_rdata", {24'd0, rdata}, 32'h3C);
    tick();
    req    = 2'b00;
    uio_in = 8'hFF;
    @(negedge clk);
    chk("t2_rdata_hold", {24'd0, rdata}, 32'h3C);
    chk("t2_gnt_end",    {30'd0, gnt},   32'd0);

    // Both requesters held continuously.
    tick();
    req   = 2'b11;
    wr    = 2'b11;
    wdata = 16'h2211;
    for (int k = 0; k < 4; k++) push_exp(t3_own[k], 1'b0, (t3_own[k] == 0) ? 8'h11 : 8'h22);
    wait_dones(4, 40, "t3_dones");
    tick();
    req = 2'b00;
    tick();

    // Request dropped and wr/wdata changed right after grant.
    req    = 2'b01;
    wr     = 2'b00;
    uio_in = 8'h5A;
    push_exp(0, 1'b1, 8'h5A);
    tick();
    req   = 2'b00;
    wr    = 2'b01;
    wdata = 16'hDEAD;
    wait_dones(1, 10, "t4_dones");
    tick();
    uio_in = 8'h00;
    tick();

    // Reset pulsed during DRIVE: pins released at once, no done, requester 0 first afterwards.
    req   = 2'b10;
    wr    = 2'b10;
    wdata = 16'h7700;
    @(negedge clk);                                  // N
    @(negedge clk);                                  // N+1: DRIVE
    chk("t5_oe_drive", {24'd0, uio_oe}, 32'hFF);
    #2;
    rst_n = 1'b1;
    #1;
    chk("t5_rst_oe",   {24'd0, uio_oe}, 32'd0);
    chk("t5_rst_gnt",  {30'd0, gnt},    32'd0);
    chk("t5_rst_busy", {31'd0, busy},   32'd0);
    chk("t5_rst_done", {30'd0, done},   32'd0);
    tick();
    chk("t5_rst_rdata", {24'd0, rdata}, 32'd0);
    rst_n = 1'b0;
    req   = 2'b11;
    wr    = 2'b11;
    wdata = 16'h2211;
    for (int k = 0; k < 2; k++) push_exp(t5_own[k], 1'b0, (t5_own[k] == 0) ? 8'h11 : 8'h22);
    wait_dones(2, 20, "t5_dones");
    tick();
    req = 2'b00;
    repeat (4) tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_port_arbiter.md
IO_PORT_ARBITER -- requirements
Module: io_port_arbiter

Interface
- REQ-001: Parameter NUM_REQ, default 2, SHALL set the number of requesters; legal range 2..4.
- REQ-002: Parameter TURN_CYCLES, default 1, SHALL set the bus turnaround length in cycles; legal range 1..7.
- REQ-003: clk  in  1  clock; all state SHALL update on its rising edge.
- REQ-004: rst_n  in  1  reset, asynchronous, active-high.
- REQ-005: req  in  NUM_REQ  per-requester transaction request, held until that requester's done pulse.
- REQ-006: wr  in  NUM_REQ  per-requester direction: 1 = write byte to pins, 0 = read byte from pins.
- REQ-007: wdata  in  NUM_REQ*8  per-requester write byte; requester i uses bits [8i+7:8i].
- REQ-008: gnt  out  NUM_REQ  one-hot owner of the pins; zero when no transaction is in progress.
- REQ-009: done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- REQ-010: rdata  out  8  last byte sampled by a read; valid while done is high; held until the next read sample.
- REQ-011: busy  out  1  high in every state except IDLE.
- REQ-012: uio_in  in  8; uio_out  out  8; uio_oe  out  8  shared bidirectional pin bus; oe bit 1 = output.

Function
- REQ-013: The FSM SHALL have the states IDLE, DRIVE, TURN, SAMPLE and RECOVER.
- REQ-014: IDLE with req != 0 SHALL latch the winner index, wr and wdata. Next state: DRIVE if wr, else TURN.
- REQ-015: DRIVE SHALL last 1 cycle with uio_oe = 8'hFF and uio_out = latched wdata, then go to RECOVER.
- REQ-016: TURN SHALL last TURN_CYCLES cycles with uio_oe = 0, then go to SAMPLE.
- REQ-017: SAMPLE SHALL last 1 cycle with uio_oe = 0, registering uio_in into rdata at the cycle's end, then go to RECOVER.
- REQ-018: RECOVER SHALL last TURN_CYCLES cycles with uio_oe = 0, then go to IDLE.
- REQ-019: done[owner] SHALL be high in the first RECOVER cycle only.
- REQ-020: gnt[owner] SHALL be high from the first cycle after IDLE through the last RECOVER cycle.
- REQ-021: Latency from req sampled in IDLE at cycle N: write done at N+2; read done at N+2+TURN_CYCLES.
- REQ-022: Back-to-back spacing SHALL be at least 1 IDLE cycle between the last RECOVER cycle and the next DRIVE/TURN.
- REQ-023: uio_out SHALL be 8'h00 in all states except DRIVE.
- REQ-024: Arbitration SHALL be round-robin. The search starts at the index after the last granted requester, wrapping from NUM_REQ-1 to 0.
- REQ-025: Deasserting req, or changing wr/wdata, mid-transaction SHALL NOT abort or alter the transaction; it completes normally.
- REQ-026: Requests arriving outside IDLE SHALL wait; none are lost while held.

Reset
- REQ-027: While rst_n = 1 the FSM SHALL be in IDLE and the outputs SHALL be: gnt = 0, done = 0, rdata = 8'h00, busy = 0, uio_oe = 8'h00, uio_out = 8'h00.
- REQ-028: Reset SHALL set the round-robin pointer so that requester 0 has highest priority.
- REQ-029: Reset asserted mid-transaction SHALL release the pins immediately (asynchronously) with no done pulse.

Configuration
- REQ-030: With IO_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the lowest index wins and the pointer logic is not built.
- REQ-031: Without IO_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-024.

Structure
- REQ-032: Package io_arb_pkg SHALL hold the FSM state enum, the byte typedef and the NUM_REQ/TURN_CYCLES range constants.
- REQ-033: The winner selection SHALL be one sub-module, rr_picker, taking req and the pointer and returning a one-hot winner.

Verification
- REQ-034: Single write: req=01, wr=01, wdata[7:0]=8'hA5 at N -> uio_oe=FF and uio_out=A5 at N+1; done=01 at N+2; gnt=00 at N+3.
- REQ-035: Single read, TURN_CYCLES=1: req=10, wr=00, uio_in=8'h3C -> uio_oe stays 00; done=10 with rdata=3C at N+3.
- REQ-036: Both requesters holding req continuously -> grants alternate 01,10,01,10. With IO_ARB_FIXED_PRIO_EN -> 01 every time.
- REQ-037: req dropped the cycle after grant -> transaction still completes with a done pulse.
- REQ-038: rst_n pulsed during DRIVE -> uio_oe=00, gnt=00, busy=0 immediately; no done pulse; next grant goes to requester 0.
